// File: rtl/mips_trace_capture.sv
// Instruction-trace capture for iitk_mini_mips.
// Circular buffer with armed trigger, post-trigger count and oldest-first readout.
module mips_trace_capture #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NCH    = 4,
    parameter int DEPTH  = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [31:0]           instr_in,
    input  logic [NCH*DATA_W-1:0] ch_in,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic [ADDR_W-1:0]     trig_pc,
    input  logic [31:0]           trig_instr,
    input  logic                  trig_ext,
    input  logic [PW-1:0]         post_cnt,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [ADDR_W-1:0]     rd_pc,
    output logic [31:0]           rd_instr,
    output logic [NCH*DATA_W-1:0] rd_ch,
    output logic                  rd_last,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [PW:0]           count,
    output logic [PW-1:0]         trig_pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    state_t state_q, state_d;

    logic [PW-1:0] wptr;
    logic [PW:0]   rptr;
    logic [PW-1:0] rem_q;
    logic [PW-1:0] post_q;
    logic          hit;
    logic          wr;
    logic          rd_ok;
    logic [PW-1:0] oldest;
    logic [PW-1:0] rd_idx;

    logic [ADDR_W-1:0]     pc_mem    [DEPTH];
    logic [31:0]           instr_mem [DEPTH];
    logic [NCH*DATA_W-1:0] ch_mem    [DEPTH];

    // Trigger condition for the sample currently presented
    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            2'd0: hit = 1'b1;
            2'd1: hit = (pc_in == trig_pc);
            2'd2: hit = (instr_in == trig_instr);
            2'd3: hit = trig_ext;
        endcase
    end

    assign wr     = !arm && valid_in &&
                    (state_q == S_ARMED || state_q == S_POST);
    assign rd_ok  = !arm && rd_en && (state_q == S_DONE) && (rptr < count);
    assign oldest = (count == FULL) ? wptr : '0;
    assign rd_idx = oldest + rptr[PW-1:0];

    // Next-state logic; arm overrides every state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_ARMED: begin
                    if (valid_in && hit)
                        state_d = (post_cnt == '0) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (valid_in && rem_q == PW'(1))
                        state_d = S_DONE;
                end
                S_DONE:  state_d = S_DONE;
            endcase
        end
    end

    // State, flags, pointers and post-trigger bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            armed     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rem_q     <= '0;
            post_q    <= '0;
        end else begin
            state_q   <= state_d;
            armed     <= (state_d == S_ARMED);
            triggered <= (state_d == S_POST) || (state_d == S_DONE);
            done      <= (state_d == S_DONE);
            if (arm) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (wr) begin
                    wptr <= wptr + PW'(1);
                    if (count != FULL)
                        count <= count + (PW+1)'(1);
                    if (state_q == S_ARMED && hit) begin
                        post_q <= post_cnt;
                        rem_q  <= post_cnt;
                    end else if (state_q == S_POST) begin
                        rem_q <= rem_q - PW'(1);
                    end
                end
                if (rd_ok)
                    rptr <= rptr + (PW+1)'(1);
            end
        end
    end

    // Buffer storage; contents survive reset by design
    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wptr]    <= pc_in;
            instr_mem[wptr] <= instr_in;
            ch_mem[wptr]    <= ch_in;
        end
    end

    // Registered read port, one entry per rd_en
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_ch    <= '0;
        end else if (rd_ok) begin
            rd_valid <= 1'b1;
            rd_last  <= (rptr == count - (PW+1)'(1));
            rd_pc    <= pc_mem[rd_idx];
            rd_instr <= instr_mem[rd_idx];
            rd_ch    <= ch_mem[rd_idx];
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

    assign trig_pos = done ? (count[PW-1:0] - PW'(1) - post_q) : '0;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Bench for mips_trace_capture.
// Directed scenarios plus random traffic against a queue-based model.
module tb_mips_trace_capture;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int CW    = NCH * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [AW-1:0] pc_in;
    logic [31:0]   instr_in;
    logic [CW-1:0] ch_in;
    logic          arm;
    logic [1:0]    trig_mode;
    logic [AW-1:0] trig_pc;
    logic [31:0]   trig_instr;
    logic          trig_ext;
    logic [PW-1:0] post_cnt;
    logic          rd_en;
    logic          rd_valid;
    logic [AW-1:0] rd_pc;
    logic [31:0]   rd_instr;
    logic [CW-1:0] rd_ch;
    logic          rd_last;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [PW:0]   count;
    logic [PW-1:0] trig_pos;

    mips_trace_capture #(
        .ADDR_W(AW), .DATA_W(DW), .NCH(NCH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
        .instr_in(instr_in), .ch_in(ch_in), .arm(arm),
        .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_instr(trig_instr),
        .trig_ext(trig_ext), .post_cnt(post_cnt), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_ch(rd_ch), .rd_last(rd_last), .armed(armed),
        .triggered(triggered), .done(done), .count(count),
        .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        logic [CW-1:0] ch;
    } ent_t;

    // Model: captured samples oldest-first, phase 0 idle,1 armed,2 post,3 done
    ent_t q[$];
    int   ph     = 0;
    int   m_rem  = 0;
    int   m_post = 0;
    int   m_rd   = 0;
    bit   e_rv;
    bit   e_last;
    ent_t e_ent;

    task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        case (trig_mode)
            2'd0:    return 1'b1;
            2'd1:    return pc_in == trig_pc;
            2'd2:    return instr_in == trig_instr;
            default: return trig_ext;
        endcase
    endfunction

    function automatic logic [CW-1:0] rnd_ch();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: advance model with the inputs at the edge, then check
    task automatic tick();
        int exp_tp;
        @(posedge clk);
        e_rv   = 0;
        e_last = 0;
        if (!reset) begin
            ph = 0; q.delete(); m_rd = 0; m_post = 0;
        end else if (arm) begin
            ph = 1; q.delete(); m_rd = 0;
        end else if ((ph == 1 || ph == 2) && valid_in) begin
            q.push_back('{pc_in, instr_in, ch_in});
            if (q.size() > DEPTH) void'(q.pop_front());
            if (ph == 1) begin
                if (model_hit()) begin
                    m_post = int'(post_cnt);
                    if (m_post == 0) ph = 3;
                    else begin ph = 2; m_rem = m_post; end
                end
            end else begin
                m_rem--;
                if (m_rem == 0) ph = 3;
            end
        end else if (ph == 3 && rd_en && m_rd < q.size()) begin
            e_rv   = 1;
            e_ent  = q[m_rd];
            e_last = (m_rd == q.size() - 1);
            m_rd++;
        end
        #1;
        exp_tp = (ph == 3) ? ((q.size() - 1 - m_post) & 15) : 0;
        chk("armed", CW'(armed), CW'(ph == 1));
        chk("triggered", CW'(triggered), CW'(ph >= 2));
        chk("done", CW'(done), CW'(ph == 3));
        chk("count", CW'(count), CW'(q.size()));
        chk("trig_pos", CW'(trig_pos), CW'(exp_tp));
        chk("rd_valid", CW'(rd_valid), CW'(e_rv));
        chk("rd_last", CW'(rd_last), CW'(e_last));
        if (e_rv) begin
            chk("rd_pc", CW'(rd_pc), CW'(e_ent.pc));
            chk("rd_instr", CW'(rd_instr), CW'(e_ent.instr));
            chk("rd_ch", rd_ch, e_ent.ch);
        end
        arm   = 0;
        rd_en = 0;
    endtask

    task automatic sample(bit v, logic [AW-1:0] pc, logic [31:0] ins,
                          logic [CW-1:0] ch);
        valid_in = v;
        pc_in    = pc;
        instr_in = ins;
        ch_in    = ch;
        tick();
    endtask

    task automatic do_arm();
        arm      = 1;
        valid_in = 1;
        pc_in    = $urandom;
        instr_in = $urandom;
        tick();
        valid_in = 0;
    endtask

    task automatic rd_one();
        valid_in = 0;
        rd_en    = 1;
        tick();
    endtask

    task automatic pc_match_run(bit bubbles);
        logic [AW-1:0] pc;
        int            n;
        trig_mode = 2'd1;
        trig_pc   = 32'h100;
        post_cnt  = 4'd5;
        do_arm();
        pc = 0;
        n  = 0;
        while (!done && n < 200) begin
            valid_in = bubbles && triggered ? n[0] : 1'b1;
            if (triggered) post_cnt = PW'($urandom);
            sample(valid_in, pc, $urandom, rnd_ch());
            if (valid_in) pc += 4;
            n++;
        end
        chk("pcm_done", CW'(done), CW'(1));
        chk("pcm_count", CW'(count), CW'(16));
        chk("pcm_trig_pos", CW'(trig_pos), CW'(10));
        for (int i = 0; i < 16; i++) begin
            rd_one();
            chk("pcm_rd_pc", CW'(rd_pc), CW'(32'hD8 + 4 * i));
        end
        rd_one();
        chk("pcm_rd_after_last", CW'(rd_valid), CW'(0));
    endtask

    initial begin
        reset = 0; valid_in = 0; pc_in = 0; instr_in = 0; ch_in = 0;
        arm = 0; trig_mode = 0; trig_pc = 0; trig_instr = 0;
        trig_ext = 0; post_cnt = 0; rd_en = 0;

        // Reset state and read attempt in IDLE
        tick();
        tick();
        chk("rst_rd_pc", CW'(rd_pc), CW'(0));
        chk("rst_rd_instr", CW'(rd_instr), CW'(0));
        chk("rst_rd_ch", rd_ch, CW'(0));
        reset = 1;
        rd_one();
        chk("idle_rd", CW'(rd_valid), CW'(0));

        // Immediate trigger
        trig_mode = 2'd0;
        post_cnt  = 4'd3;
        do_arm();
        for (int i = 0; i < 4; i++)
            sample(1, 32'(4 * i), $urandom, rnd_ch());
        chk("imm_done", CW'(done), CW'(1));
        chk("imm_count", CW'(count), CW'(4));
        chk("imm_trig_pos", CW'(trig_pos), CW'(0));
        for (int i = 0; i < 4; i++) begin
            rd_one();
            chk("imm_rd_pc", CW'(rd_pc), CW'(4 * i));
            chk("imm_rd_last", CW'(rd_last), CW'(i == 3));
        end
        rd_one();

        // PC match with wrap, then with bubbles after the trigger
        pc_match_run(1'b0);
        pc_match_run(1'b1);

        // Instruction match and channel readback
        trig_mode  = 2'd2;
        trig_instr = 32'h012A4020;
        post_cnt   = 4'd2;
        do_arm();
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                sample(1, 32'(i * 4), 32'h012A4020,
                       {32'h1003, 32'h1002, 32'h1001, 32'h1000});
            else
                sample(1, 32'(i * 4), $urandom | 32'h8000_0000, rnd_ch());
        end
        chk("im_trig_pos", CW'(trig_pos), CW'(3));
        for (int i = 0; i < 6; i++) begin
            rd_one();
            if (i == 3)
                chk("im_rd_ch", rd_ch,
                    {32'h1003, 32'h1002, 32'h1001, 32'h1000});
        end

        // External trigger only honoured on valid cycles
        trig_mode = 2'd3;
        post_cnt  = 4'd1;
        do_arm();
        trig_ext = 0;
        sample(1, 32'h40, $urandom, rnd_ch());
        trig_ext = 1;
        sample(0, 32'h44, $urandom, rnd_ch());
        trig_ext = 0;
        sample(1, 32'h48, $urandom, rnd_ch());
        chk("ext_no_trig", CW'(triggered), CW'(0));
        trig_ext = 1;
        sample(1, 32'h4C, $urandom, rnd_ch());
        trig_ext = 0;
        sample(1, 32'h50, $urandom, rnd_ch());
        chk("ext_done", CW'(done), CW'(1));

        // Arm together with read in DONE
        arm   = 1;
        rd_en = 1;
        tick();
        chk("col_rd_valid", CW'(rd_valid), CW'(0));
        chk("col_count", CW'(count), CW'(0));
        chk("col_armed", CW'(armed), CW'(1));

        // Arm in POST restarts
        trig_mode = 2'd0;
        post_cnt  = 4'd4;
        sample(1, 32'h0, $urandom, rnd_ch());
        sample(1, 32'h4, $urandom, rnd_ch());
        do_arm();
        chk("rearm_trig", CW'(triggered), CW'(0));

        // Reset mid-POST
        post_cnt = 4'd8;
        for (int i = 0; i < 3; i++)
            sample(1, 32'(i * 4), $urandom, rnd_ch());
        reset = 0;
        sample(1, 32'h20, $urandom, rnd_ch());
        sample(1, 32'h24, $urandom, rnd_ch());
        chk("rst_count", CW'(count), CW'(0));
        chk("rst_done", CW'(done), CW'(0));
        chk("rst_armed", CW'(armed), CW'(0));
        reset = 1;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 299) != 0);
            arm        = ($urandom_range(0, 39) == 0);
            rd_en      = $urandom_range(0, 1);
            valid_in   = ($urandom_range(0, 3) != 0);
            trig_mode  = 2'($urandom);
            trig_pc    = 32'($urandom_range(0, 15) * 4);
            trig_instr = 32'($urandom_range(0, 7));
            trig_ext   = ($urandom_range(0, 7) == 0);
            post_cnt   = PW'($urandom);
            pc_in      = 32'($urandom_range(0, 15) * 4);
            instr_in   = 32'($urandom_range(0, 7));
            ch_in      = rnd_ch();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
